avalon_pio_responder: RTL and testbench
=======================================

Name: avalon_pio_responder

Overview:
- Avalon-MM slave (responder) peripheral answering Nios II load/store transactions to board I/O.
- Debounces and synchronises board inputs (SW, KEY) and captures their edges with a maskable interrupt.
- Drives a register-backed output bus (LEDR, HEX segment bits).
- Sits inside the de1_soc top as the responder end of the processor's data-bus accesses to PIO space.

Parameters:
- IN_W, 10, width of synchronised input bus (1..32).
- OUT_W, 10, width of output register (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a debounced bit changes (10 ms at 50 MHz); must be ≥1.
- EDGE_MODE, 0, edges captured: 0 rising, 1 falling, 2 both.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  synchronous reset, active-high.
- avs_address  input  2  word address of register.
- avs_read  input  1  read strobe, single cycle.
- avs_write  input  1  write strobe, single cycle.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, registered.
- avs_readdatavalid  output  1  high one cycle when avs_readdata is valid.
- pio_in  input  IN_W  asynchronous board inputs.
- pio_out  output  OUT_W  output register contents.
- irq  output  1  level interrupt request.

Behaviour:
Interface decision:
- One clock (clk); reset (rst) is synchronous and active-high.
- All state, including synchroniser flops, clears on the clk edge where rst=1.

Register map (word addresses):
- 0 IN: read-only, debounced inputs in [IN_W-1:0].
- 1 OUT: read/write, pio_out.
- 2 IRQMASK: read/write, [IN_W-1:0].
- 3 EDGECAP: read; write-1-to-clear.
- Unimplemented upper bits read 0. Writes to IN are ignored.

Bus timing:
- No waitrequest; fixed read latency 1.
- avs_read at cycle N → avs_readdata and avs_readdatavalid=1 at N+1.
- avs_readdata holds its last value when avs_readdatavalid=0.
- Writes take effect on the same edge: the register shows the new value from N+1.
- avs_read and avs_write asserted together: the write is performed and the read returns the pre-write value.

Input path, per bit:
- Two-flop synchroniser, then debouncer.
- Counter (width clog2(DEBOUNCE_CYCLES+1)) increments while synced ≠ stable; it clears when they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1 and the bit still differs, stable takes synced and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Total latency from a pio_in change to an IN change: DEBOUNCE_CYCLES+2 cycles.
- At reset, stable is set to 0. Inputs held at 1 through reset therefore produce one rising edge after debounce, and this is required behaviour.

Edge capture:
- Event when stable changes in the direction selected by EDGE_MODE.
- The event sets the EDGECAP bit (sticky).
- A write of 1 clears the bit; a write of 0 leaves it unchanged.
- A new edge in the same cycle as the clearing write leaves the bit set (edge wins).

Interrupt:
- irq = |(EDGECAP & IRQMASK), registered, so it asserts one cycle after the EDGECAP/IRQMASK update.
- Clearing the last pending bit deasserts irq one cycle later.

Reset values:
- pio_out=0, avs_readdata=0, avs_readdatavalid=0, irq=0.
- IRQMASK=0, EDGECAP=0, all debounce counters and stable bits = 0.
- Reset mid-read suppresses avs_readdatavalid in the following cycle.

Test Plan:
- Reset, then write OUT=0x3A5 → pio_out=0x3A5 next cycle; read addr 1 → readdata=0x000003A5 with readdatavalid=1 exactly one cycle after avs_read; upper bits 0.
- DEBOUNCE_CYCLES=4: pio_in[0] high for 3 cycles then low → IN stays 0, EDGECAP=0. Hold high 10 cycles → IN[0]=1 at DEBOUNCE_CYCLES+2 cycles after the change; EDGECAP[0]=1.
- IRQMASK=0x001, rising edge on bit 0 → irq=1 one cycle after EDGECAP set. Write EDGECAP=0x002 → irq stays 1. Write 0x001 → irq=0 next cycle.
- Write-1-clear of EDGECAP[3] on the same cycle bit 3 debounces high → EDGECAP[3] remains 1.
- EDGE_MODE=2: toggle pio_in[5] 1→0 with stable hold → EDGECAP[5]=1. Then, with EDGE_MODE=1, a rising edge is not captured.
- Simultaneous read+write to addr 1 (old 0x0F, new 0xF0) → readdata=0x0F, pio_out=0xF0. Assert rst during a pending read → readdatavalid=0 and all outputs return to reset values.

Source files
------------

// File: rtl/avalon_pio_responder.sv
// avalon_pio_responder: Avalon-MM responder for board PIO.
// Synchronises and debounces IN_W board inputs, captures their edges into a
// sticky write-1-to-clear register with a maskable level interrupt, and
// drives an OUT_W-bit register-backed output bus. Fixed read latency of one
// cycle, no waitrequest.
module avalon_pio_responder #(
   parameter int IN_W            = 10,
   parameter int OUT_W           = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int EDGE_MODE       = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              avs_readdatavalid,
   input  logic [IN_W-1:0]   pio_in,
   output logic [OUT_W-1:0]  pio_out,
   output logic              irq
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ADDR_IN      = 2'd0,
      ADDR_OUT     = 2'd1,
      ADDR_IRQMASK = 2'd2,
      ADDR_EDGECAP = 2'd3
   } reg_addr_e;

   logic [IN_W-1:0]  sync1;
   logic [IN_W-1:0]  sync2;
   logic [IN_W-1:0]  stable;
   logic [IN_W-1:0]  stable_next;
   logic [CNT_W-1:0] cnt [IN_W];

   logic [IN_W-1:0]  rise_evt;
   logic [IN_W-1:0]  fall_evt;
   logic [IN_W-1:0]  edge_evt;
   logic [IN_W-1:0]  cap_clr;
   logic [IN_W-1:0]  irq_mask;
   logic [IN_W-1:0]  edge_cap;
   logic [OUT_W-1:0] out_reg;
   logic [31:0]      read_mux;
   reg_addr_e        addr;

   // Bits of the write bus above the register widths are deliberately ignored.
   logic unused_wdata;
   assign unused_wdata = ^avs_writedata;

   assign addr    = reg_addr_e'(avs_address);
   assign pio_out = out_reg;

   // Synchroniser chain and per-bit debounce counters.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         // NOTE: cnt is a small array of flops, not a RAM, so it is cleared with the rest of the state.
         for (int i = 0; i < IN_W; i++) cnt[i] <= '0;
      end else begin
         sync1  <= pio_in;
         sync2  <= sync1;
         stable <= stable_next;
         for (int i = 0; i < IN_W; i++) begin
            if (sync2[i] == stable[i] || cnt[i] == CNT_LAST) cnt[i] <= '0;
            else                                           cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // A bit adopts the synced value once it has differed for DEBOUNCE_CYCLES cycles.
   always_comb begin
      // NOTE: default first so no path through this block leaves stable_next unassigned (no latch).
      stable_next = stable;
      for (int i = 0; i < IN_W; i++) begin
         if (sync2[i] != stable[i] && cnt[i] == CNT_LAST) stable_next[i] = sync2[i];
      end
   end

   assign rise_evt = stable_next & ~stable;
   assign fall_evt = ~stable_next & stable;
   assign edge_evt = (EDGE_MODE == 0) ? rise_evt :
                     (EDGE_MODE == 1) ? fall_evt : (rise_evt | fall_evt);

   assign cap_clr = (avs_write && addr == ADDR_EDGECAP) ? avs_writedata[IN_W-1:0] : '0;

   // Read multiplexer over the pre-write register contents.
   always_comb begin
      read_mux = '0;
      unique case (addr)
         ADDR_IN:      read_mux = 32'(stable);
         ADDR_OUT:     read_mux = 32'(out_reg);
         ADDR_IRQMASK: read_mux = 32'(irq_mask);
         ADDR_EDGECAP: read_mux = 32'(edge_cap);
         default:      read_mux = '0;
      endcase
   end

   // Writable registers, sticky edge capture and the registered interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg  <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         irq      <= 1'b0;
      end else begin
         if (avs_write) begin
            unique case (addr)
               ADDR_OUT:     out_reg  <= avs_writedata[OUT_W-1:0];
               ADDR_IRQMASK: irq_mask <= avs_writedata[IN_W-1:0];
               default:      ;
            endcase
         end
         // A new edge overrides a simultaneous clear of the same bit.
         edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
         irq      <= |(edge_cap & irq_mask);
      end
   end

   // Read response: data one cycle after the strobe, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= avs_read;
         if (avs_read) avs_readdata <= read_mux;
      end
   end

endmodule

// File: tb/tb_avalon_pio_responder.sv
// Self-checking bench for avalon_pio_responder. Three instances share all
// inputs and differ only in EDGE_MODE (rising, falling, both), so edge-mode
// behaviour is compared side by side under identical stimulus.
module tb_avalon_pio_responder;

   localparam int IN_W  = 10;
   localparam int OUT_W = 10;
   localparam int D     = 4;

   logic              clk;
   logic              rst;
   logic [1:0]        avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [IN_W-1:0]   pio_in;
   logic [31:0]       rd   [3];
   logic              rdv  [3];
   logic [OUT_W-1:0]  pout [3];
   logic              irqo [3];

   int n_checks = 0;
   int n_errors = 0;

   avalon_pio_responder #(.IN_W(IN_W), .OUT_W(OUT_W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) dut_rise (
      .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd[0]),
      .avs_readdatavalid(rdv[0]), .pio_in(pio_in), .pio_out(pout[0]), .irq(irqo[0]));

   avalon_pio_responder #(.IN_W(IN_W), .OUT_W(OUT_W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) dut_fall (
      .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd[1]),
      .avs_readdatavalid(rdv[1]), .pio_in(pio_in), .pio_out(pout[1]), .irq(irqo[1]));

   avalon_pio_responder #(.IN_W(IN_W), .OUT_W(OUT_W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut_both (
      .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd[2]),
      .avs_readdatavalid(rdv[2]), .pio_in(pio_in), .pio_out(pout[2]), .irq(irqo[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // hist[k] is pio_in as sampled k clock edges ago. A debounced bit flips
   // when the D samples taken 2..D+1 edges ago all disagree with it.
   logic [IN_W-1:0]  hist [1:D+1];
   logic [IN_W-1:0]  m_in;
   logic [OUT_W-1:0] m_out;
   logic [IN_W-1:0]  m_mask;
   logic [IN_W-1:0]  m_cap [3];
   logic [31:0]      m_rd  [3];
   logic             m_rdv;
   logic             m_irq [3];

   function automatic logic [31:0] reg_val(int k, logic [1:0] a);
      case (a)
         2'd0:    return {{(32-IN_W){1'b0}}, m_in};
         2'd1:    return {{(32-OUT_W){1'b0}}, m_out};
         2'd2:    return {{(32-IN_W){1'b0}}, m_mask};
         default: return {{(32-IN_W){1'b0}}, m_cap[k]};
      endcase
   endfunction

   task automatic model_step();
      logic [IN_W-1:0] nxt;
      logic [IN_W-1:0] rise;
      logic [IN_W-1:0] fall;
      logic [IN_W-1:0] clr;
      logic            diff;
      if (rst) begin
         for (int j = 1; j <= D + 1; j++) hist[j] = '0;
         m_in = '0; m_out = '0; m_mask = '0; m_rdv = 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_cap[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
         end
         return;
      end
      m_rdv = avs_read;
      for (int k = 0; k < 3; k++) begin
         if (avs_read) m_rd[k] = reg_val(k, avs_address);
         m_irq[k] = |(m_cap[k] & m_mask);
      end
      for (int b = 0; b < IN_W; b++) begin
         diff = 1'b1;
         for (int j = 2; j <= D + 1; j++) if (hist[j][b] == m_in[b]) diff = 1'b0;
         nxt[b] = diff ? ~m_in[b] : m_in[b];
      end
      rise = nxt & ~m_in;
      fall = ~nxt & m_in;
      clr  = '0;
      if (avs_write) begin
         case (avs_address)
            2'd1:    m_out  = avs_writedata[OUT_W-1:0];
            2'd2:    m_mask = avs_writedata[IN_W-1:0];
            2'd3:    clr    = avs_writedata[IN_W-1:0];
            default: ;
         endcase
      end
      m_cap[0] = (m_cap[0] & ~clr) | rise;
      m_cap[1] = (m_cap[1] & ~clr) | fall;
      m_cap[2] = (m_cap[2] & ~clr) | rise | fall;
      m_in = nxt;
      for (int j = D + 1; j >= 2; j--) hist[j] = hist[j-1];
      hist[1] = pio_in;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      cycle();
      avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a);
      avs_address = a; avs_read = 1'b1;
      cycle();
      avs_read = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) cycle();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (pout[k] !== '0 || rdv[k] !== 1'b0 || irqo[k] !== 1'b0 || rd[k] !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs dut%0d: pio_out=%h rdv=%b irq=%b readdata=%h, expected all 0",
                     k, pout[k], rdv[k], irqo[k], rd[k]);
         end
      end
      rst = 1'b0;
      cycle();
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a));
         n_checks++;
         if (rd[0] !== 32'h0 || rdv[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_reg%0d: readdata=%h rdv=%b, expected 00000000 rdv=1", a, rd[0], rdv[0]);
         end
      end
   endtask

   task automatic test_out_rw();
      bus_write(2'd1, 32'hABCD_E3A5);
      n_checks++;
      if (pout[0] !== 10'h3A5) begin
         n_errors++;
         $display("FAIL out_write: pio_out=%h, expected 3a5", pout[0]);
      end
      n_checks++;
      if (rdv[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL out_rdv_idle: rdv=%b, expected 0", rdv[0]);
      end
      bus_read(2'd1);
      n_checks++;
      if (rd[0] !== 32'h0000_03A5 || rdv[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL out_readback: readdata=%h rdv=%b, expected 000003a5 rdv=1", rd[0], rdv[0]);
      end
      cycle();
      n_checks++;
      if (rd[0] !== 32'h0000_03A5 || rdv[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL out_hold: readdata=%h rdv=%b, expected 000003a5 rdv=0", rd[0], rdv[0]);
      end
   endtask

   task automatic test_glitch();
      pio_in[0] = 1'b1;
      repeat (D - 1) cycle();
      pio_in[0] = 1'b0;
      repeat (12) cycle();
      bus_read(2'd0);
      n_checks++;
      if (rd[0] !== 32'h0) begin
         n_errors++;
         $display("FAIL glitch_in: IN=%h, expected 00000000", rd[0]);
      end
      bus_read(2'd3);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rd[k] !== 32'h0) begin
            n_errors++;
            $display("FAIL glitch_edgecap dut%0d: EDGECAP=%h, expected 00000000", k, rd[k]);
         end
      end
   endtask

   task automatic test_debounce_irq();
      logic [31:0] exp_v;
      bus_write(2'd2, 32'h0000_0001);
      pio_in[0] = 1'b1;
      avs_address = 2'd0;
      avs_read = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         cycle();
         // IN flips on edge D+2; the continuous read shows it one edge later.
         exp_v = (t >= D + 3) ? 32'h1 : 32'h0;
         n_checks++;
         if (rd[0] !== exp_v || rd[0] !== m_rd[0]) begin
            n_errors++;
            $display("FAIL debounce_in t=%0d: IN=%h, expected %h", t, rd[0], exp_v);
         end
         n_checks++;
         if (irqo[0] !== (t >= D + 3)) begin
            n_errors++;
            $display("FAIL debounce_irq t=%0d: irq=%b, expected %b", t, irqo[0], (t >= D + 3));
         end
      end
      avs_read = 1'b0;
      bus_read(2'd3);
      n_checks++;
      if (rd[0] !== 32'h1 || rd[1] !== 32'h0 || rd[2] !== 32'h1) begin
         n_errors++;
         $display("FAIL debounce_edgecap: rise=%h fall=%h both=%h, expected 1 0 1", rd[0], rd[1], rd[2]);
      end
      bus_write(2'd3, 32'h0000_0002);
      cycle();
      n_checks++;
      if (irqo[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL irq_clear_other: irq=%b, expected 1", irqo[0]);
      end
      bus_write(2'd3, 32'h0000_0001);
      n_checks++;
      if (irqo[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL irq_clear_lag: irq=%b, expected 1", irqo[0]);
      end
      cycle();
      n_checks++;
      if (irqo[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL irq_cleared: irq=%b, expected 0", irqo[0]);
      end
   endtask

   task automatic test_edge_wins();
      pio_in[3] = 1'b1;
      repeat (D + 1) cycle();
      // This clear lands on the same edge where bit 3 debounces high.
      bus_write(2'd3, 32'h0000_0008);
      bus_read(2'd3);
      n_checks++;
      if (rd[0] !== 32'h8 || rd[1] !== 32'h0 || rd[2] !== 32'h8) begin
         n_errors++;
         $display("FAIL edge_wins: rise=%h fall=%h both=%h, expected 8 0 8", rd[0], rd[1], rd[2]);
      end
      bus_write(2'd3, 32'h0000_0008);
      bus_read(2'd3);
      n_checks++;
      if (rd[0] !== 32'h0 || rd[2] !== 32'h0) begin
         n_errors++;
         $display("FAIL w1c_plain: rise=%h both=%h, expected 0 0", rd[0], rd[2]);
      end
   endtask

   task automatic test_edge_modes();
      pio_in[5] = 1'b1;
      repeat (D + 3) cycle();
      bus_write(2'd3, 32'h0000_03FF);
      pio_in[5] = 1'b0;
      repeat (D + 3) cycle();
      bus_read(2'd3);
      n_checks++;
      if (rd[0] !== 32'h0 || rd[1] !== 32'h20 || rd[2] !== 32'h20) begin
         n_errors++;
         $display("FAIL falling_edge: rise=%h fall=%h both=%h, expected 0 20 20", rd[0], rd[1], rd[2]);
      end
      bus_write(2'd3, 32'h0000_03FF);
      pio_in[5] = 1'b1;
      repeat (D + 3) cycle();
      bus_read(2'd3);
      n_checks++;
      if (rd[0] !== 32'h20 || rd[1] !== 32'h0 || rd[2] !== 32'h20) begin
         n_errors++;
         $display("FAIL rising_edge: rise=%h fall=%h both=%h, expected 20 0 20", rd[0], rd[1], rd[2]);
      end
   endtask

   task automatic test_rw_same();
      bus_write(2'd1, 32'h0000_000F);
      avs_address = 2'd1; avs_writedata = 32'h0000_00F0;
      avs_read = 1'b1; avs_write = 1'b1;
      cycle();
      avs_read = 1'b0; avs_write = 1'b0;
      n_checks++;
      if (rd[0] !== 32'h0F || rdv[0] !== 1'b1 || pout[0] !== 10'h0F0) begin
         n_errors++;
         $display("FAIL rw_same: readdata=%h rdv=%b pio_out=%h, expected 0000000f 1 0f0",
                  rd[0], rdv[0], pout[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rd[k] !== m_rd[k] || rdv[k] !== m_rdv || irqo[k] !== m_irq[k] || pout[k] !== m_out) begin
               n_errors++;
               $display("FAIL random dut%0d cycle %0d: rd=%h rdv=%b irq=%b out=%h, expected rd=%h rdv=%b irq=%b out=%h",
                        k, i, rd[k], rdv[k], irqo[k], pout[k], m_rd[k], m_rdv, m_irq[k], m_out);
            end
         end
         if ($urandom_range(0, 4) == 0) pio_in[$urandom_range(0, IN_W - 1)] ^= 1'b1;
         avs_address   = 2'($urandom_range(0, 3));
         avs_writedata = $urandom;
         avs_read      = ($urandom_range(0, 1) == 1);
         avs_write     = ($urandom_range(0, 2) == 0);
         cycle();
      end
      avs_read = 1'b0; avs_write = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      pio_in = 10'h2A1;
      avs_address = 2'd1; avs_read = 1'b1; rst = 1'b1;
      cycle();
      avs_read = 1'b0; rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rdv[k] !== 1'b0 || rd[k] !== 32'h0 || pout[k] !== '0 || irqo[k] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_read dut%0d: rdv=%b rd=%h out=%h irq=%b, expected all 0",
                     k, rdv[k], rd[k], pout[k], irqo[k]);
         end
      end
      bus_read(2'd2);
      n_checks++;
      if (rd[0] !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_irqmask: IRQMASK=%h, expected 00000000", rd[0]);
      end
      bus_read(2'd0);
      n_checks++;
      if (rd[0] !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_in: IN=%h, expected 00000000", rd[0]);
      end
      // Inputs held high through reset yield one rising edge after debounce.
      repeat (10) cycle();
      bus_read(2'd3);
      n_checks++;
      if (rd[0] !== 32'h2A1 || rd[1] !== 32'h0 || rd[2] !== 32'h2A1) begin
         n_errors++;
         $display("FAIL post_reset_edge: rise=%h fall=%h both=%h, expected 2a1 0 2a1", rd[0], rd[1], rd[2]);
      end
   endtask

   initial begin
      rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = '0; pio_in = '0;
      test_reset();
      test_out_rw();
      test_glitch();
      test_debounce_irq();
      test_edge_wins();
      test_edge_modes();
      test_rw_same();
      test_random();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
